// File: rtl/vram_pkg.sv
// Shared types and sizes for the VRAM write scheduler.
package vram_pkg;
    localparam int unsigned VRAM_ADDR_W = 11;
    localparam int unsigned VRAM_DATA_W = 32;
    localparam int unsigned BUF_WORDS   = 1024;
    localparam int unsigned OFFS_W      = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } vram_sched_state_t;

    // Full VRAM address: buffer select bit above the in-buffer word offset.
    function automatic logic [VRAM_ADDR_W-1:0] vram_addr(input logic buf_sel,
                                                         input logic [OFFS_W-1:0] offset);
        return {buf_sel, offset};
    endfunction
endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU write request channel into the VRAM write scheduler.
interface vram_write_scheduler_if;
    import vram_pkg::*;

    logic                   cpu_req;
    logic [OFFS_W-1:0]      cpu_addr;
    logic [VRAM_DATA_W-1:0] cpu_data;
    logic                   cpu_ack;

    modport master (output cpu_req, output cpu_addr, output cpu_data, input cpu_ack);
    modport slave  (input cpu_req, input cpu_addr, input cpu_data, output cpu_ack);
endinterface

// File: rtl/vram_clear_engine.sv
// Back-buffer fill engine: latched fill word and a non-wrapping offset counter.
module vram_clear_engine
    import vram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   advance,
    input  logic [VRAM_DATA_W-1:0] fill_in,
    output logic [OFFS_W-1:0]      offset,
    output logic [VRAM_DATA_W-1:0] fill_value,
    output logic                   done
);
    logic [OFFS_W-1:0] count;

    // done flags that the offset currently on offer is the last word of the buffer
    assign done   = (count == OFFS_W'(BUF_WORDS - 1));
    assign offset = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            fill_value <= '0;
        end else if (start) begin
            count      <= '0;
            fill_value <= fill_in;
        end else if (advance && !done) begin
            count <= count + OFFS_W'(1);
        end
    end
endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates CPU writes, buffer clears and front/back swaps onto one VRAM write port.
// Optional feature macro: VRAM_SCHED_ROUND_ROBIN_EN (CPU/clear round-robin during CLEAR).
module vram_write_scheduler
    import vram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    vram_write_scheduler_if.slave  cpu,
    input  logic                   clear_req,
    input  logic [VRAM_DATA_W-1:0] clear_value,
    input  logic                   swap_req,
    input  logic                   frame_done,
    output logic                   use_secondary_buffer,
    output logic [VRAM_ADDR_W-1:0] vram_wraddress,
    output logic [VRAM_DATA_W-1:0] vram_data,
    output logic                   vram_wren,
    output logic                   busy
);
    vram_sched_state_t state, state_next;
    logic swap_pending, pending_next;
    logic cpu_ack_c, cpu_grant, clr_grant, clr_start, swap_now;
    logic [OFFS_W-1:0]      clr_offset;
    logic [VRAM_DATA_W-1:0] clr_value;
    logic                   clr_done;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
    logic cpu_turn, turn_next;
`endif

    vram_clear_engine u_clear (
        .clk        (clk),
        .rst        (rst),
        .start      (clr_start),
        .advance    (clr_grant),
        .fill_in    (clear_value),
        .offset     (clr_offset),
        .fill_value (clr_value),
        .done       (clr_done)
    );

    assign cpu.cpu_ack = cpu_ack_c;

    // Next-state, grant and handshake decode
    always_comb begin
        state_next   = state;
        pending_next = swap_pending;
        cpu_ack_c    = 1'b0;
        cpu_grant    = 1'b0;
        clr_grant    = 1'b0;
        clr_start    = 1'b0;
        swap_now     = 1'b0;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
        turn_next    = cpu_turn;
`endif
        case (state)
            IDLE: begin
                cpu_ack_c = 1'b1;
                cpu_grant = cpu.cpu_req;
                if (clear_req) begin
                    clr_start    = 1'b1;
                    pending_next = swap_req;
                    state_next   = CLEAR;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
                    turn_next    = 1'b1;
`endif
                end else if (swap_req) begin
                    pending_next = 1'b1;
                    state_next   = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (swap_req) pending_next = 1'b1;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
                cpu_ack_c = cpu_turn;
                cpu_grant = cpu.cpu_req && cpu_turn;
                clr_grant = !cpu_grant;
                turn_next = !cpu_grant;
`else
                clr_grant = 1'b1;
`endif
                if (clr_grant && clr_done)
                    state_next = pending_next ? SWAP_WAIT : IDLE;
            end
            SWAP_WAIT: begin
                if (frame_done) begin
                    swap_now     = 1'b1;
                    pending_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, write port and buffer select registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            swap_pending         <= 1'b0;
            use_secondary_buffer <= 1'b0;
            vram_wren            <= 1'b0;
            vram_wraddress       <= '0;
            vram_data            <= '0;
            busy                 <= 1'b0;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
            cpu_turn             <= 1'b1;
`endif
        end else begin
            state        <= state_next;
            swap_pending <= pending_next;
            busy         <= (state_next != IDLE) || pending_next;
            vram_wren    <= cpu_grant || clr_grant;
            if (cpu_grant) begin
                vram_wraddress <= vram_addr(!use_secondary_buffer, cpu.cpu_addr);
                vram_data      <= cpu.cpu_data;
            end else if (clr_grant) begin
                vram_wraddress <= vram_addr(!use_secondary_buffer, clr_offset);
                vram_data      <= clr_value;
            end
            if (swap_now) use_secondary_buffer <= !use_secondary_buffer;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
            cpu_turn <= turn_next;
`endif
        end
    end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed self-checking bench for vram_write_scheduler (either arbitration build).
module tb_vram_write_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic [31:0] clear_value;
    logic        swap_req;
    logic        frame_done;
    logic        use_secondary_buffer;
    logic [10:0] vram_wraddress;
    logic [31:0] vram_data;
    logic        vram_wren;
    logic        busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    vram_write_scheduler_if cpu_if ();

    vram_write_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .cpu                  (cpu_if),
        .clear_req            (clear_req),
        .clear_value          (clear_value),
        .swap_req             (swap_req),
        .frame_done           (frame_done),
        .use_secondary_buffer (use_secondary_buffer),
        .vram_wraddress       (vram_wraddress),
        .vram_data            (vram_data),
        .vram_wren            (vram_wren),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        chk_cnt++; if (vram_wren !== 1'b0) $display("FAIL reset_wren got %b exp 0", vram_wren); else pass_cnt++;
        chk_cnt++; if (vram_wraddress !== 11'h000) $display("FAIL reset_addr got %h exp 000", vram_wraddress); else pass_cnt++;
        chk_cnt++; if (vram_data !== 32'h0) $display("FAIL reset_data got %h exp 0", vram_data); else pass_cnt++;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL reset_usb got %b exp 0", use_secondary_buffer); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++; if (cpu_if.cpu_ack !== 1'b1) $display("FAIL idle_ack got %b exp 1", cpu_if.cpu_ack); else pass_cnt++;
    endtask

    task automatic test_cpu_write();
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_addr = 10'd5;
        cpu_if.cpu_data = 32'hDEADBEEF;
        #1;
        chk_cnt++; if (cpu_if.cpu_ack !== 1'b1) $display("FAIL wr_ack got %b exp 1", cpu_if.cpu_ack); else pass_cnt++;
        step();
        cpu_if.cpu_req = 1'b0;
        chk_cnt++; if (vram_wren !== 1'b1) $display("FAIL wr_wren got %b exp 1", vram_wren); else pass_cnt++;
        chk_cnt++; if (vram_wraddress !== 11'h405) $display("FAIL wr_addr got %h exp 405", vram_wraddress); else pass_cnt++;
        chk_cnt++; if (vram_data !== 32'hDEADBEEF) $display("FAIL wr_data got %h exp deadbeef", vram_data); else pass_cnt++;
        step();
        chk_cnt++; if (vram_wren !== 1'b0) $display("FAIL wr_idle_wren got %b exp 0", vram_wren); else pass_cnt++;
    endtask

    task automatic test_clear();
        int bad = 0;
        logic [10:0] ea;
        clear_value = 32'h00FF00FF;
        clear_req   = 1'b1;
        step();
        clear_req = 1'b0;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL clr_busy got %b exp 1", busy); else pass_cnt++;
        for (int i = 0; i < 1024; i++) begin
            step();
            ea = 11'h400 + 11'(i);
            if (vram_wren !== 1'b1 || vram_wraddress !== ea || vram_data !== 32'h00FF00FF) bad++;
        end
        chk_cnt++; if (bad !== 0) $display("FAIL clr_seq got %0d bad writes exp 0", bad); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_done_busy got %b exp 0", busy); else pass_cnt++;
        step();
        chk_cnt++; if (vram_wren !== 1'b0) $display("FAIL clr_after_wren got %b exp 0", vram_wren); else pass_cnt++;
    endtask

    task automatic test_clear_then_swap();
        int good = 0;
        clear_value = 32'h12345678;
        clear_req   = 1'b1;
        swap_req    = 1'b1;
        step();
        clear_req = 1'b0;
        swap_req  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (vram_wren === 1'b1 && vram_data === 32'h12345678 && vram_wraddress[10] === 1'b1) good++;
        end
        chk_cnt++; if (good !== 1024) $display("FAIL cs_writes got %0d exp 1024", good); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL cs_wait_busy got %b exp 1", busy); else pass_cnt++;
        repeat (9) step();
        chk_cnt++; if (cpu_if.cpu_ack !== 1'b0) $display("FAIL cs_wait_ack got %b exp 0", cpu_if.cpu_ack); else pass_cnt++;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL cs_pre_usb got %b exp 0", use_secondary_buffer); else pass_cnt++;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk_cnt++; if (use_secondary_buffer !== 1'b1) $display("FAIL cs_usb got %b exp 1", use_secondary_buffer); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL cs_busy got %b exp 0", busy); else pass_cnt++;
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_addr = 10'd0;
        cpu_if.cpu_data = 32'hA5A5A5A5;
        step();
        cpu_if.cpu_req = 1'b0;
        chk_cnt++; if (vram_wraddress !== 11'h000 || vram_wren !== 1'b1)
            $display("FAIL cs_wr_addr got %h/%b exp 000/1", vram_wraddress, vram_wren); else pass_cnt++;
    endtask

    task automatic test_cpu_during_clear();
        int cycles = 0, clr_w = 0, cpu_w = 0, ack_hi = 0;
        logic first_ack;
        cpu_if.cpu_req  = 1'b1;
        cpu_if.cpu_addr = 10'd7;
        cpu_if.cpu_data = 32'h11110000;
        clear_value     = 32'hCAFE0000;
        clear_req       = 1'b1;
        step();
        clear_req = 1'b0;
        first_ack = cpu_if.cpu_ack;
        while (busy === 1'b1 && cycles < 5000) begin
            if (cpu_if.cpu_ack === 1'b1) ack_hi++;
            step();
            cycles++;
            if (vram_wren === 1'b1 && vram_data === 32'hCAFE0000) clr_w++;
            if (vram_wren === 1'b1 && vram_data === 32'h11110000) cpu_w++;
        end
        cpu_if.cpu_req = 1'b0;
`ifdef VRAM_SCHED_ROUND_ROBIN_EN
        chk_cnt++; if (cycles !== 2048) $display("FAIL rr_cycles got %0d exp 2048", cycles); else pass_cnt++;
        chk_cnt++; if (first_ack !== 1'b1) $display("FAIL rr_first_ack got %b exp 1", first_ack); else pass_cnt++;
        chk_cnt++; if (cpu_w !== 1024) $display("FAIL rr_cpu_writes got %0d exp 1024", cpu_w); else pass_cnt++;
        chk_cnt++; if (ack_hi !== 1024) $display("FAIL rr_ack_cycles got %0d exp 1024", ack_hi); else pass_cnt++;
`else
        chk_cnt++; if (cycles !== 1024) $display("FAIL prio_cycles got %0d exp 1024", cycles); else pass_cnt++;
        chk_cnt++; if (first_ack !== 1'b0) $display("FAIL prio_first_ack got %b exp 0", first_ack); else pass_cnt++;
        chk_cnt++; if (cpu_w !== 0) $display("FAIL prio_cpu_writes got %0d exp 0", cpu_w); else pass_cnt++;
        chk_cnt++; if (ack_hi !== 0) $display("FAIL prio_ack_cycles got %0d exp 0", ack_hi); else pass_cnt++;
`endif
        chk_cnt++; if (clr_w !== 1024) $display("FAIL cpuclr_clear_writes got %0d exp 1024", clr_w); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_abort();
        clear_value = 32'h0BADF00D;
        clear_req   = 1'b1;
        swap_req    = 1'b1;
        step();
        clear_req = 1'b0;
        swap_req  = 1'b0;
        repeat (300) step();
        chk_cnt++; if (vram_wraddress !== 11'd299) $display("FAIL ab_addr got %h exp 12b", vram_wraddress); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (vram_wren !== 1'b0) $display("FAIL ab_wren got %b exp 0", vram_wren); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL ab_usb got %b exp 0", use_secondary_buffer); else pass_cnt++;
        step();
        chk_cnt++; if (vram_wren !== 1'b0 || busy !== 1'b0)
            $display("FAIL ab_no_resume got wren=%b busy=%b exp 0/0", vram_wren, busy); else pass_cnt++;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL ab_swap_dropped got %b exp 0", use_secondary_buffer); else pass_cnt++;
    endtask

    task automatic test_frame_done_idle();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL fd_idle_usb got %b exp 0", use_secondary_buffer); else pass_cnt++;
        swap_req   = 1'b1;
        frame_done = 1'b1;
        step();
        swap_req   = 1'b0;
        frame_done = 1'b0;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL fd_wait_busy got %b exp 1", busy); else pass_cnt++;
        chk_cnt++; if (cpu_if.cpu_ack !== 1'b0) $display("FAIL fd_wait_ack got %b exp 0", cpu_if.cpu_ack); else pass_cnt++;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk_cnt++; if (use_secondary_buffer !== 1'b0) $display("FAIL fd_entry_usb got %b exp 0", use_secondary_buffer); else pass_cnt++;
        repeat (4) step();
        chk_cnt++; if (cpu_if.cpu_ack !== 1'b0) $display("FAIL fd_wait_ack2 got %b exp 0", cpu_if.cpu_ack); else pass_cnt++;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk_cnt++; if (use_secondary_buffer !== 1'b1) $display("FAIL fd_usb got %b exp 1", use_secondary_buffer); else pass_cnt++;
        step();
        chk_cnt++; if (busy !== 1'b0 || vram_wren !== 1'b0)
            $display("FAIL fd_clear_ignored got busy=%b wren=%b exp 0/0", busy, vram_wren); else pass_cnt++;
    endtask

    initial begin
        rst             = 1'b1;
        clear_req       = 1'b0;
        clear_value     = 32'h0;
        swap_req        = 1'b0;
        frame_done      = 1'b0;
        cpu_if.cpu_req  = 1'b0;
        cpu_if.cpu_addr = 10'd0;
        cpu_if.cpu_data = 32'h0;
        test_reset();
        test_cpu_write();
        test_clear();
        test_clear_then_swap();
        test_cpu_during_clear();
        test_reset_abort();
        test_frame_done_idle();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
